// File: rtl/psum_deskew_drain.sv
// psum_deskew_drain: deskews the systolic array's bottom-row partial sums into a
// result buffer, then drains it one row per valid/ready handshake.
module psum_deskew_drain #(
  parameter int N  = 10,
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  psum_valid,
  input  logic [N*DW-1:0]       psum_in,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [N*DW-1:0]       row_data,
  output logic [$clog2(N)-1:0]  row_idx,
  output logic                  row_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(2*N-1);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] rd_q, rd_d;
  logic done_q, done_d, ovr_q, ovr_d;
  logic [N*DW-1:0] buf_q [N];
  logic [N*DW-1:0] buf_d [N];
  logic [N*DW-1:0] aligned;
  logic clr, shift;
  assign clr   = state_q == IDLE && start;
  assign shift = state_q == CAPTURE && psum_valid;
  // Lane j delays by N-1-j beats; stage 0 sits in the low bits, oldest beat on top.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign aligned[j*DW +: DW] = psum_in[j*DW +: DW];
    end else begin : g_sr
      logic [D*DW-1:0] sr_q, sr_d;
      always_comb sr_d = clr ? '0 : shift ? ((sr_q << DW) | (D*DW)'(psum_in[j*DW +: DW])) : sr_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) sr_q <= '0;
        else sr_q <= sr_d;
      assign aligned[j*DW +: DW] = sr_q[D*DW-1 -: DW];
    end
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (psum_valid && state_q != CAPTURE);
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CAPTURE;
        beat_d  = '0;
        ovr_d   = 1'b0;
      end
      CAPTURE: if (psum_valid) begin
        beat_d = beat_q + 1'b1;
        for (int r = 0; r < N; r++)
          if (beat_q == BW'(r + N - 1)) buf_d[r] = aligned;
        if (beat_q == BW'(2*N - 2)) begin
          state_d = DRAIN;
          rd_d    = '0;
        end
      end
      DRAIN: if (row_ready) begin
        rd_d = rd_q + 1'b1;
        if (rd_q == IW'(N - 1)) begin
          state_d = IDLE;
          rd_d    = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int r = 0; r < N; r++) buf_q[r] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      buf_q   <= buf_d;
    end
  end
  assign row_valid = state_q == DRAIN;
  assign row_data  = row_valid ? buf_q[rd_q] : '0;
  assign row_idx   = rd_q;
  assign row_last  = row_valid && rd_q == IW'(N - 1);
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign overrun   = ovr_q;
endmodule
